// File: rtl/spi_slave_rx_mode1_pkg.sv
// Shared definitions for the mode-1 SPI slave receiver: bus mode constants,
// default geometry and the receive FSM state type.
package spi_pkg;

    localparam logic        SPI_CPOL        = 1'b0;
    localparam logic        SPI_CPHA        = 1'b1;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_mode1_sync_edge.sv
// Single-pin synchronizer with registered rise/fall detection.
// o_level is the synchronized level that the edge pulses were derived from,
// so data pins sampled through o_level stay aligned with clock-pin pulses.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES  = DEF_SYNC_STAGES,
    parameter logic        RST_VAL = SPI_CPOL
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    // Synchronizer chain, previous-value flop and registered edge pulses
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
            r_rise <= ~r_prev &  r_sync[STAGES-1];
            r_fall <=  r_prev & ~r_sync[STAGES-1];
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_rx_mode1.sv
// SPI mode-1 (CPOL=0, CPHA=1) slave receiver, oversampled by In_clk.
// Optional feature macro: SPI_SLAVE_RX_OVERRUN_EN adds a sticky overrun flag
// (Out_rx_overrun, cleared by In_clr_err) and drops words that arrive while
// the previous one is still unaccepted; without it, new words overwrite.
module spi_slave_rx_mode1
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              In_clk,
    input  logic              In_rst_n,
    input  logic              In_spi_cs_n,
    input  logic              In_spi_sclk,
    input  logic              In_spi_mosi,
    input  logic              In_rx_ready,
    output logic              Out_rx_valid,
    output logic [DATA_W-1:0] Out_rx_data,
    output logic              Out_rx_busy,
    output logic              Out_frame_err
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    ,
    output logic              Out_rx_overrun,
    input  logic              In_clr_err
`endif
);

    localparam int unsigned     CNT_W          = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DATA_W - 1);
    localparam logic            SAMPLE_ON_FALL = SPI_CPOL ^ SPI_CPHA;

    spi_state_e        r_state;
    spi_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic              r_overrun;
`endif

    logic              w_cs_level_unused;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic              w_sclk_level_unused;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_mosi;
    logic              w_mosi_rise_unused;
    logic              w_mosi_fall_unused;
    logic              w_sclk_edge;
    logic              w_busy;
    logic              w_start;
    logic              w_abort;
    logic              w_shift_en;
    logic              w_word_done;
    logic [DATA_W-1:0] w_new_word;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk   (In_clk),
        .i_rst_n (In_rst_n),
        .i_async (In_spi_cs_n),
        .o_level (w_cs_level_unused),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sclk (
        .i_clk   (In_clk),
        .i_rst_n (In_rst_n),
        .i_async (In_spi_sclk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk   (In_clk),
        .i_rst_n (In_rst_n),
        .i_async (In_spi_mosi),
        .o_level (w_mosi),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    // Mode 1 samples on the trailing SCLK edge, which is the falling edge
    assign w_sclk_edge = SAMPLE_ON_FALL ? w_sclk_fall : w_sclk_rise;
    assign w_new_word  = {r_shift[DATA_W-2:0], w_mosi};

    // FSM state register
    always_ff @(posedge In_clk) begin
        if (!In_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: CS assertion opens a frame, deassertion closes it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_nxt = ST_RECV;
            ST_RECV: if (w_cs_rise) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; CS deassertion takes priority over a coincident SCLK edge
    always_comb begin
        w_busy      = (r_state == ST_RECV);
        w_start     = (r_state == ST_IDLE) && w_cs_fall;
        w_abort     = (r_state == ST_RECV) && w_cs_rise;
        w_shift_en  = (r_state == ST_RECV) && !w_cs_rise && w_sclk_edge;
        w_word_done = w_shift_en && (r_cnt == CNT_LAST);
    end

    // Bit counter and shift register, cleared at frame start and end
    always_ff @(posedge In_clk) begin
        if (!In_rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_start || w_abort) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_new_word;
            r_cnt   <= w_word_done ? '0 : r_cnt + 1'b1;
        end
    end

    // Frame error pulse when CS closes with a partial word
    always_ff @(posedge In_clk) begin
        if (!In_rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_abort && (r_cnt != '0);
        end
    end

    // Output word register with valid/ready handshake
    always_ff @(posedge In_clk) begin
        if (!In_rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
            r_overrun <= 1'b0;
`endif
        end else begin
`ifdef SPI_SLAVE_RX_OVERRUN_EN
            if (In_clr_err) begin
                r_overrun <= 1'b0;
            end
            // A completed word only loads if the slot is free or being emptied
            if (w_word_done && r_valid && !In_rx_ready) begin
                r_overrun <= 1'b1;
            end else if (w_word_done) begin
                r_data  <= w_new_word;
                r_valid <= 1'b1;
            end else if (r_valid && In_rx_ready) begin
                r_valid <= 1'b0;
            end
`else
            if (w_word_done) begin
                r_data  <= w_new_word;
                r_valid <= 1'b1;
            end else if (r_valid && In_rx_ready) begin
                r_valid <= 1'b0;
            end
`endif
        end
    end

    assign Out_rx_valid   = r_valid;
    assign Out_rx_data    = r_data;
    assign Out_rx_busy    = w_busy;
    assign Out_frame_err  = r_frame_err;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    assign Out_rx_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_spi_slave_rx_mode1.sv
// Self-checking bench for spi_slave_rx_mode1 (default geometry, 8-bit words).
// Honours SPI_SLAVE_RX_OVERRUN_EN when the design is built with it.
module tb_spi_slave_rx_mode1;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs_n;
    logic          sclk;
    logic          mosi;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          busy;
    logic          ferr;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic          overrun;
    logic          clr_err;
`endif

    always #5 clk = ~clk;

    spi_slave_rx_mode1 #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .In_clk         (clk),
        .In_rst_n       (rst_n),
        .In_spi_cs_n    (cs_n),
        .In_spi_sclk    (sclk),
        .In_spi_mosi    (mosi),
        .In_rx_ready    (ready),
        .Out_rx_valid   (valid),
        .Out_rx_data    (data),
        .Out_rx_busy    (busy),
        .Out_frame_err  (ferr)
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        ,
        .Out_rx_overrun (overrun),
        .In_clr_err     (clr_err)
`endif
    );

    // ---------------- monitor (sampled on the falling clock edge) ----------
    logic [7:0]  got[$];
    int unsigned err_cnt   = 0;
    int unsigned gap_cnt   = 0;
    int unsigned idle_hits = 0;
    logic        in_frame   = 1'b0;
    logic        watch_idle = 1'b0;
    logic        rand_ready = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) got.push_back(data);
        if (ferr === 1'b1) err_cnt++;
        if (in_frame && busy !== 1'b1) gap_cnt++;
        if (watch_idle && (busy !== 1'b0 || valid !== 1'b0 || ferr !== 1'b0)) idle_hits++;
    end

    // ---------------- scoring -----------------------------------------------
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] got_at(input int idx);
        if (idx < got.size()) return {24'h0, got[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    // ---------------- stimulus helpers (drive 2 time units after posedge) --
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic spi_bit(input logic b, input int half);
        sclk = 1'b1;
        mosi = b;
        wait_cyc(half);
        sclk = 1'b0;
        wait_cyc(half);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) spi_bit(b[7-i], half);
    endtask

    task automatic cs_on();
        cs_n = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cs_off();
        wait_cyc(6);
        cs_n = 1'b1;
        wait_cyc(8);
    endtask

    // ---------------- vector table -----------------------------------------
    typedef struct {
        logic [7:0] val;
        int         nbits;
        int         half;
        int         exp_words;
        logic [7:0] exp_data;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    // Watchdog: the whole run is fixed-length; this only guards against a hang
    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : main
        int unsigned base;
        int unsigned e0;
        int unsigned g0;
        int unsigned h0;
        logic [7:0]  exp_q[$];
        logic [7:0]  b;

        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; ready = 1'b1;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        clr_err = 1'b0;
`endif
        wait_cyc(3);
        check("reset_outputs", {22'h0, valid, data, busy, ferr}, 32'h0);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        check("reset_overrun", {31'h0, overrun}, 32'h0);
`endif
        rst_n = 1'b1;
        wait_cyc(5);

        // val, bits, half-period, words, data, frame errors
        vecs[0] = '{8'hA5, 8, 10, 1, 8'hA5, 0};
        vecs[1] = '{8'hFF, 8,  4, 1, 8'hFF, 0};
        vecs[2] = '{8'h00, 8,  5, 1, 8'h00, 0};
        vecs[3] = '{8'h80, 8,  7, 1, 8'h80, 0};
        vecs[4] = '{8'h3C, 5,  6, 0, 8'h00, 1};
        vecs[5] = '{8'h81, 1,  6, 0, 8'h00, 1};
        vecs[6] = '{8'h7E, 7,  4, 0, 8'h00, 1};
        vecs[7] = '{8'h00, 0,  6, 0, 8'h00, 0};

        for (int v = 0; v < 8; v++) begin
            base = got.size();
            e0   = err_cnt;
            cs_on();
            send_bits(vecs[v].val, vecs[v].nbits, vecs[v].half);
            cs_off();
            check($sformatf("vec%0d_words", v), got.size() - base, vecs[v].exp_words);
            if (vecs[v].exp_words > 0)
                check($sformatf("vec%0d_data", v), got_at(base), {24'h0, vecs[v].exp_data});
            check($sformatf("vec%0d_frame_err", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("vec%0d_idle", v), {31'h0, busy}, 32'h0);
        end

        // Two back-to-back words in one frame, busy never drops
        base = got.size(); e0 = err_cnt; g0 = gap_cnt;
        cs_on();
        in_frame = 1'b1;
        send_bits(8'h3C, 8, 8);
        send_bits(8'hC3, 8, 8);
        in_frame = 1'b0;
        cs_off();
        check("b2b_words", got.size() - base, 2);
        check("b2b_first", got_at(base), 32'h3C);
        check("b2b_second", got_at(base + 1), 32'hC3);
        check("b2b_busy_gaps", gap_cnt - g0, 0);
        check("b2b_frame_err", err_cnt - e0, 0);

        // Latency: valid rises on the 4th clock edge after SCLK is first sampled low
        cs_on();
        send_bits(8'hB6, 7, 6);
        sclk = 1'b1; mosi = 1'b0;
        wait_cyc(6);
        sclk = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("latency_early", {31'h0, valid}, 32'h0);
        @(posedge clk);
        #1 check("latency_edge", {31'h0, valid}, 32'h1);
        check("latency_data", {24'h0, data}, 32'hB6);
        #1;
        wait_cyc(6);
        cs_off();

        // Word completes in the same cycle the pending word is accepted
        base = got.size();
        ready = 1'b0;
        cs_on();
        send_bits(8'h44, 8, 6);
        send_bits(8'h55, 7, 6);
        sclk = 1'b1; mosi = 1'b1;
        wait_cyc(6);
        sclk = 1'b0;
        repeat (3) @(posedge clk);
        #2 ready = 1'b1;
        @(posedge clk);
        #2 ready = 1'b0;
        check("same_cycle_valid", {31'h0, valid}, 32'h1);
        check("same_cycle_data", {24'h0, data}, 32'h55);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        check("same_cycle_no_overrun", {31'h0, overrun}, 32'h0);
`endif
        wait_cyc(6);
        cs_off();
        ready = 1'b1;
        wait_cyc(2);
        check("same_cycle_words", got.size() - base, 2);
        check("same_cycle_first", got_at(base), 32'h44);
        check("same_cycle_second", got_at(base + 1), 32'h55);

        // Consumer stalled across two words
        base = got.size();
        ready = 1'b0;
        cs_on();
        send_bits(8'h11, 8, 6);
        send_bits(8'h22, 8, 6);
        cs_off();
        check("stall_valid", {31'h0, valid}, 32'h1);
        check("stall_none_taken", got.size() - base, 0);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        check("stall_data_kept", {24'h0, data}, 32'h11);
        check("stall_overrun", {31'h0, overrun}, 32'h1);
        wait_cyc(3);
        check("stall_overrun_sticky", {31'h0, overrun}, 32'h1);
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        wait_cyc(1);
        check("stall_overrun_cleared", {31'h0, overrun}, 32'h0);
        check("stall_valid_after_clr", {31'h0, valid}, 32'h1);
`else
        check("stall_data_overwritten", {24'h0, data}, 32'h22);
`endif
        ready = 1'b1;
        wait_cyc(2);
        check("stall_released", {31'h0, valid}, 32'h0);

        // Reset in the middle of a word, CS held low throughout
        base = got.size(); e0 = err_cnt;
        cs_on();
        send_bits(8'h5A, 4, 6);
        rst_n = 1'b0;
        wait_cyc(3);
        check("midreset_outputs", {22'h0, valid, data, busy, ferr}, 32'h0);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        check("midreset_overrun", {31'h0, overrun}, 32'h0);
`endif
        rst_n = 1'b1;
        wait_cyc(8);
        check("midreset_new_frame", {31'h0, busy}, 32'h1);
        send_bits(8'h5A, 8, 6);
        cs_off();
        check("midreset_words", got.size() - base, 1);
        check("midreset_data", got_at(base), 32'h5A);
        check("midreset_no_err", err_cnt - e0, 0);

        // SCLK activity with CS deasserted is ignored
        base = got.size();
        h0 = idle_hits;
        watch_idle = 1'b1;
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom_range(0, 1)), 5);
        watch_idle = 1'b0;
        check("cs_high_activity", idle_hits - h0, 0);
        check("cs_high_words", got.size() - base, 0);

        // Randomized frames against a frame-level model
        for (int f = 0; f < 20; f++) begin
            int nbytes;
            int half;
            int partial;
            nbytes  = $urandom_range(1, 3);
            half    = $urandom_range(4, 12);
            partial = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
            exp_q.delete();
            base = got.size(); e0 = err_cnt; g0 = gap_cnt;
            rand_ready = 1'b1;
            cs_on();
            in_frame = 1'b1;
            for (int k = 0; k < nbytes; k++) begin
                b = 8'($urandom());
                exp_q.push_back(b);
                send_bits(b, 8, half);
            end
            send_bits(8'($urandom()), partial, half);
            in_frame = 1'b0;
            cs_off();
            rand_ready = 1'b0;
            ready = 1'b1;
            wait_cyc(2);
            check($sformatf("rnd%0d_words", f), got.size() - base, exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                check($sformatf("rnd%0d_word%0d", f, k), got_at(base + k), {24'h0, exp_q[k]});
            check($sformatf("rnd%0d_frame_err", f), err_cnt - e0, (partial != 0) ? 1 : 0);
            check($sformatf("rnd%0d_busy_gaps", f), gap_cnt - g0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_mode1.md
SPI_SLAVE_RX_MODE1 -- requirements
Module: spi_slave_rx_mode1

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the frame word width in bits, MSB first.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (minimum 2), giving the synchronizer depth for SPI pin inputs.
REQ-003 The block SHALL have port In_clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port In_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port In_spi_cs_n, input, 1 bit: asynchronous SPI chip select, active-low.
REQ-006 The block SHALL have port In_spi_sclk, input, 1 bit: asynchronous SPI clock, mode 1 (CPOL=0, CPHA=1).
REQ-007 The block SHALL have port In_spi_mosi, input, 1 bit: asynchronous SPI data, master-driven.
REQ-008 The block SHALL have port In_rx_ready, input, 1 bit: consumer accepts Out_rx_data when high with Out_rx_valid.
REQ-009 The block SHALL have port Out_rx_valid, output, 1 bit: Out_rx_data holds a received word.
REQ-010 The block SHALL have port Out_rx_data, output, DATA_W bits: received word.
REQ-011 The block SHALL have port Out_rx_busy, output, 1 bit: high while in state RECV.
REQ-012 The block SHALL have port Out_frame_err, output, 1 bit: one-cycle pulse when CS deasserts mid-word.
REQ-013 The block SHALL have port Out_rx_overrun, output, 1 bit, present only under SPI_SLAVE_RX_OVERRUN_EN: sticky overrun flag.
REQ-014 The block SHALL have port In_clr_err, input, 1 bit, present only under SPI_SLAVE_RX_OVERRUN_EN: clears Out_rx_overrun.

Function
REQ-015 The block SHALL pass CS_N, SCLK and MOSI through SYNC_STAGES flops each, then one further flop per signal for edge detection.
REQ-016 The block SHALL detect an SCLK falling edge as previous=1 and current=0 at the synchronizer outputs; rising edges SHALL be ignored.
REQ-017 The block SHALL sample MOSI from the synchronized MOSI stage aligned with the synchronized SCLK stage used for edge detection.
REQ-018 The block SHALL implement FSM IDLE/RECV: IDLE to RECV on synchronized CS_N falling, clearing bit counter and shift register.
REQ-019 In RECV, each SCLK falling edge SHALL shift synchronized MOSI into the shift register LSB and increment the bit counter (0..DATA_W-1).
REQ-020 On the DATA_W-th falling edge, the block SHALL load the complete word into the output register, set Out_rx_valid, and wrap the counter to 0 while staying in RECV (back-to-back words).
REQ-021 Out_rx_valid SHALL rise on the (SYNC_STAGES+2)th In_clk rising edge after the first edge that samples In_spi_sclk low.
REQ-022 Out_rx_valid SHALL hold, with Out_rx_data stable, until a cycle with In_rx_ready=1, after which it clears.
REQ-023 If a word completes in the same cycle as valid&ready, the new word SHALL load, Out_rx_valid SHALL remain 1, and no overrun SHALL be recorded.
REQ-024 When synchronized CS_N rises in RECV, the block SHALL go to IDLE, discard the partial word, and pulse Out_frame_err if the bit counter is nonzero.
REQ-025 SCLK edges while synchronized CS_N is high SHALL be ignored.
REQ-026 Correct operation SHALL require SCLK high and low phases of at least SYNC_STAGES+2 In_clk periods each.

Reset
REQ-027 While In_rst_n=0 at an In_clk edge, the block SHALL reset state to IDLE, counter/shift register/Out_rx_data to 0, and Out_rx_valid, Out_rx_busy, Out_frame_err, Out_rx_overrun to 0.
REQ-028 Reset SHALL preset CS synchronizer flops to 1, and SCLK and MOSI synchronizer flops to 0.
REQ-029 Reset mid-word SHALL discard the word without a frame-error pulse, and a still-low CS_N after release SHALL start a new frame.

Configuration
REQ-030 With SPI_SLAVE_RX_OVERRUN_EN defined, a word completing while valid=1 and ready=0 SHALL be dropped, the old word retained, and Out_rx_overrun set until In_clr_err=1.
REQ-031 Without SPI_SLAVE_RX_OVERRUN_EN, the new word SHALL overwrite Out_rx_data with valid held, and the ports Out_rx_overrun and In_clr_err SHALL not exist.

Structure
REQ-032 Package spi_pkg SHALL hold SPI_CPOL=0, SPI_CPHA=1, the default DATA_W and SYNC_STAGES, and the FSM state enum.
REQ-033 The block SHALL instantiate sub-module spi_sync_edge (synchronizer plus rise/fall detect) once per pin input.

Verification
REQ-034 Bench SHALL cover: CS low, byte 0xA5 at SCLK period 20 In_clk, ready=1 -> one valid pulse, data 0xA5, frame_err=0.
REQ-035 Bench SHALL cover: one CS frame carrying 0x3C,0xC3, ready=1 -> two valid pulses, in order, busy high throughout.
REQ-036 Bench SHALL cover: CS rises after 5 bits -> frame_err pulses once, no valid, state IDLE.
REQ-037 Bench SHALL cover: ready=0, bytes 0x11 then 0x22 -> with macro, data 0x11 and overrun=1 until clr_err; without macro, data 0x22.
REQ-038 Bench SHALL cover: In_rst_n low after bit 4 then released, CS still low, byte 0x5A -> all outputs 0 during reset, then data 0x5A.
REQ-039 Bench SHALL cover: SCLK toggling with CS high -> no valid and busy=0.
